// File: rtl/spi_cfg_controller.sv
// Two-requester SPI config-write controller: 16-bit frame plus commit clock.
// Optional macro SPI_CFG_SKIP_REDUNDANT_EN suppresses writes matching shadows.
module spi_cfg_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a_valid,
  output logic       req_a_ready,
  input  logic [6:0] req_a_addr,
  input  logic [7:0] req_a_data,
  input  logic       req_b_valid,
  output logic       req_b_ready,
  input  logic [6:0] req_b_addr,
  input  logic [7:0] req_b_data,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_COMMIT,
    S_HOLD,
    S_GAP
  } state_e;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] SET_M1 = 8'(CS_SETUP - 1);
  localparam logic [7:0] IDL_M1 = 8'(CS_IDLE - 1);

  state_e      state_q;
  logic [7:0]  ph_q;
  logic [7:0]  dly_q;
  logic [4:0]  bit_q;
  logic [14:0] sh_q;
  logic [6:0]  addr_q;
  logic [7:0]  data_q;
  logic        last_b_q;
  logic        rdy_a_q;
  logic        rdy_b_q;
  logic        sclk_q;
  logic        ncs_q;
  logic        copi_q;
  logic        busy_q;
  logic        done_q;

  logic        gnt_a_d;
  logic        gnt_b_d;
  logic        open_d;
  logic        take_d;
  logic        hit_d;

  always_comb begin
    gnt_a_d = req_a_valid && (last_b_q || !req_b_valid);
    gnt_b_d = req_b_valid && !gnt_a_d;
    open_d  = ((state_q == S_IDLE) && !(rdy_a_q || rdy_b_q)) ||
              ((state_q == S_GAP) && (dly_q == IDL_M1));
    take_d  = open_d && (gnt_a_d || gnt_b_d);
  end

`ifdef SPI_CFG_SKIP_REDUNDANT_EN
  logic [7:0] shadow_q [0:4];

  always_comb begin
    hit_d = 1'b0;
    if (addr_q <= 7'd4) begin
      hit_d = (shadow_q[addr_q[2:0]] == data_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else if (done_q && (addr_q <= 7'd4)) begin
      shadow_q[addr_q[2:0]] <= data_q;
    end
  end
`else
  assign hit_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ph_q     <= '0;
      dly_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      last_b_q <= 1'b1;
      rdy_a_q  <= 1'b0;
      rdy_b_q  <= 1'b0;
      sclk_q   <= 1'b0;
      ncs_q    <= 1'b1;
      copi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rdy_a_q <= 1'b0;
      rdy_b_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rdy_a_q || rdy_b_q) begin
            if (hit_d) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              ncs_q   <= 1'b0;
              copi_q  <= 1'b1;
              sh_q    <= {addr_q, data_q};
              dly_q   <= '0;
              state_q <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (dly_q == SET_M1) begin
            ph_q    <= '0;
            bit_q   <= '0;
            state_q <= S_SHIFT;
          end else begin
            dly_q <= dly_q + 8'd1;
          end
        end
        S_SHIFT: begin
          if (ph_q == DIV_M1) begin
            ph_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              sh_q   <= {sh_q[13:0], 1'b0};
              if (bit_q == 5'd15) begin
                copi_q  <= 1'b0;
                bit_q   <= 5'd16;
                state_q <= S_COMMIT;
              end else begin
                copi_q <= sh_q[14];
                bit_q  <= bit_q + 5'd1;
              end
            end
          end else begin
            ph_q <= ph_q + 8'd1;
          end
        end
        S_COMMIT: begin
          if (ph_q == DIV_M1) begin
            ph_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q  <= 1'b0;
              state_q <= S_HOLD;
            end
          end else begin
            ph_q <= ph_q + 8'd1;
          end
        end
        S_HOLD: begin
          if (ph_q == DIV_M1) begin
            ph_q    <= '0;
            ncs_q   <= 1'b1;
            done_q  <= 1'b1;
            dly_q   <= '0;
            state_q <= S_GAP;
          end else begin
            ph_q <= ph_q + 8'd1;
          end
        end
        S_GAP: begin
          if (dly_q == IDL_M1) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            dly_q <= dly_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // accept can fire in the last GAP cycle so ready lands in the first IDLE cycle
      if (take_d) begin
        rdy_a_q  <= gnt_a_d;
        rdy_b_q  <= gnt_b_d;
        last_b_q <= gnt_b_d;
        busy_q   <= 1'b1;
        addr_q   <= gnt_a_d ? req_a_addr : req_b_addr;
        data_q   <= gnt_a_d ? req_a_data : req_b_data;
      end
    end
  end

  assign req_a_ready = rdy_a_q;
  assign req_b_ready = rdy_b_q;
  assign sclk        = sclk_q;
  assign ncs         = ncs_q;
  assign copi        = copi_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Directed bench for spi_cfg_controller: frame shape, arbitration, reset,
// divider variant and redundant-write skipping.
module tb_spi_cfg_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_v, b_v;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_rdy, b_rdy, sclk, ncs, copi, busy, fdone;

  logic       v2;
  logic [6:0] addr2;
  logic [7:0] data2;
  logic       rdy2, rdyb2, sclk2, ncs2, copi2, busy2, fd2;

  int checks = 0;
  int failures = 0;

  spi_cfg_controller u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(a_v), .req_a_ready(a_rdy),
    .req_a_addr(a_addr), .req_a_data(a_data),
    .req_b_valid(b_v), .req_b_ready(b_rdy),
    .req_b_addr(b_addr), .req_b_data(b_data),
    .sclk(sclk), .ncs(ncs), .copi(copi),
    .busy(busy), .frame_done(fdone)
  );

  spi_cfg_controller #(.CLK_DIV(3), .CS_SETUP(2), .CS_IDLE(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(v2), .req_a_ready(rdy2),
    .req_a_addr(addr2), .req_a_data(data2),
    .req_b_valid(1'b0), .req_b_ready(rdyb2),
    .req_b_addr(7'd0), .req_b_data(8'd0),
    .sclk(sclk2), .ncs(ncs2), .copi(copi2),
    .busy(busy2), .frame_done(fd2)
  );

  int rises = 0, ncs_run = 0, last_low = 0, low_total = 0;
  int fd_cnt = 0, ra_cnt = 0, rb_cnt = 0;
  logic sclk_p = 1'b0;
  logic [31:0] copi_log = '0;

  always @(negedge clk) begin
    if (sclk && !sclk_p) begin
      rises++;
      copi_log = {copi_log[30:0], copi};
    end
    sclk_p = sclk;
    if (!ncs) begin
      ncs_run++;
      low_total++;
    end else if (ncs_run > 0) begin
      last_low = ncs_run;
      ncs_run = 0;
    end
    if (fdone) fd_cnt++;
    if (a_rdy) ra_cnt++;
    if (b_rdy) rb_cnt++;
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_write(input logic [6:0] ad, input logic [7:0] dt,
                          output int lat, output int bcyc, output int nlow);
    int n0;
    int cyc;
    bit got;
    n0 = low_total;
    lat = -1;
    bcyc = 0;
    cyc = 0;
    got = 0;
    a_addr = ad;
    a_data = dt;
    a_v = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (a_rdy) got = 1;
    end
    a_v = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL wr_ready_timeout got=0 exp=1");
    end else begin
      if (busy) bcyc = 1;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        cyc++;
        if (fdone && lat < 0) lat = cyc;
        if (busy) bcyc++;
        if (lat >= 0 && !busy) break;
      end
    end
    repeat (3) @(negedge clk);
    nlow = low_total - n0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ncs !== 1'b1) begin failures++; $display("FAIL rst_ncs got=%b exp=1", ncs); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", sclk); end
    checks++; if (copi !== 1'b0) begin failures++; $display("FAIL rst_copi got=%b exp=0", copi); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (fdone !== 1'b0) begin failures++; $display("FAIL rst_fdone got=%b exp=0", fdone); end
    checks++; if ({a_rdy, b_rdy} !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", {a_rdy, b_rdy}); end
    checks++; if (ncs2 !== 1'b1) begin failures++; $display("FAIL rst_ncs2 got=%b exp=1", ncs2); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int r0, f0, a0, lat, bcyc, nlow;
    logic [16:0] exp_bits;
    exp_bits = {1'b1, 7'b0000100, 8'b10000000, 1'b0};
    r0 = rises; f0 = fd_cnt; a0 = ra_cnt;
    do_write(7'h04, 8'h80, lat, bcyc, nlow);
    checks++; if (rises - r0 != 17) begin failures++; $display("FAIL sf_rises got=%0d exp=17", rises - r0); end
    checks++; if (copi_log[16:0] !== exp_bits) begin failures++; $display("FAIL sf_bits got=%b exp=%b", copi_log[16:0], exp_bits); end
    checks++; if (last_low != 144) begin failures++; $display("FAIL sf_ncs_low got=%0d exp=144", last_low); end
    checks++; if (nlow != 144) begin failures++; $display("FAIL sf_ncs_total got=%0d exp=144", nlow); end
    checks++; if (fd_cnt - f0 != 1) begin failures++; $display("FAIL sf_done_cnt got=%0d exp=1", fd_cnt - f0); end
    checks++; if (ra_cnt - a0 != 1) begin failures++; $display("FAIL sf_ready_len got=%0d exp=1", ra_cnt - a0); end
    checks++; if (lat != 145) begin failures++; $display("FAIL sf_done_lat got=%0d exp=145", lat); end
    checks++; if (bcyc != 149) begin failures++; $display("FAIL sf_busy_len got=%0d exp=149", bcyc); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] aa [3];
    logic [7:0] ad [3];
    logic [6:0] ba [3];
    logic [7:0] bd [3];
    int order [6];
    int n, ai, bi, hi_run, min_gap, falls, f0;
    logic ncs_p;
    logic [16:0] exp_last;
    aa = '{7'h01, 7'h02, 7'h03}; ad = '{8'hA1, 8'hA2, 8'hA3};
    ba = '{7'h11, 7'h12, 7'h13}; bd = '{8'hB1, 8'hB2, 8'hB3};
    exp_last = {1'b1, 7'h13, 8'hB3, 1'b0};
    pulse_reset();
    n = 0; ai = 0; bi = 0; hi_run = 0; min_gap = 1000; falls = 0;
    ncs_p = 1'b1; f0 = fd_cnt;
    a_addr = aa[0]; a_data = ad[0]; a_v = 1'b1;
    b_addr = ba[0]; b_data = bd[0]; b_v = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (a_rdy && n < 6) begin
        order[n] = 0; n++; ai++;
        if (ai < 3) begin a_addr = aa[ai]; a_data = ad[ai]; end
        else a_v = 1'b0;
      end
      if (b_rdy && n < 6) begin
        order[n] = 1; n++; bi++;
        if (bi < 3) begin b_addr = ba[bi]; b_data = bd[bi]; end
        else b_v = 1'b0;
      end
      if (ncs) hi_run++;
      else if (ncs_p) begin
        if (falls > 0 && hi_run < min_gap) min_gap = hi_run;
        falls++;
        hi_run = 0;
      end
      ncs_p = ncs;
      if (n == 6 && !busy) break;
    end
    a_v = 1'b0; b_v = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (n != 6) begin failures++; $display("FAIL b2b_grants got=%0d exp=6", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (order[i] != (i % 2)) begin
        failures++;
        $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, order[i], i % 2);
      end
    end
    checks++; if (fd_cnt - f0 != 6) begin failures++; $display("FAIL b2b_frames got=%0d exp=6", fd_cnt - f0); end
    checks++; if (min_gap < 4) begin failures++; $display("FAIL b2b_gap got=%0d exp>=4", min_gap); end
    checks++; if (copi_log[16:0] !== exp_last) begin failures++; $display("FAIL b2b_last_bits got=%b exp=%b", copi_log[16:0], exp_last); end
  endtask

  task automatic test_busy_wait();
    int r0, cyc, fd_at, lat, bcyc, nlow;
    bit got, early;
    logic [16:0] exp_b;
    exp_b = {1'b1, 7'h03, 8'hC3, 1'b0};
    pulse_reset();
    got = 0; early = 0; fd_at = -1; cyc = 0;
    a_addr = 7'h02; a_data = 8'h3C; a_v = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (a_rdy) got = 1;
    end
    a_v = 1'b0;
    r0 = rises;
    for (int k = 0; k < 100 && rises < r0 + 2; k++) @(negedge clk);
    checks++; if (rises < r0 + 2) begin failures++; $display("FAIL bw_shift_reached got=%0d exp=2", rises - r0); end
    b_addr = 7'h03; b_data = 8'hC3; b_v = 1'b1;
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (fdone && fd_at < 0) fd_at = cyc;
      if (b_rdy) begin
        got = 1;
        if (fd_at < 0) early = 1;
      end
    end
    b_v = 1'b0;
    checks++; if (!got || early) begin failures++; $display("FAIL bw_ready got=%0d early=%0d exp=1,0", got, early); end
    checks++; if (cyc - fd_at != 4) begin failures++; $display("FAIL bw_ready_delay got=%0d exp=4", cyc - fd_at); end
    @(negedge clk);
    checks++; if (ncs !== 1'b0) begin failures++; $display("FAIL bw_ncs_fall got=%b exp=0", ncs); end
    for (int k = 0; k < 400 && busy; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (copi_log[16:0] !== exp_b) begin failures++; $display("FAIL bw_b_bits got=%b exp=%b", copi_log[16:0], exp_b); end
    lat = 0; bcyc = 0; nlow = 0;
  endtask

  task automatic test_reset_mid();
    int r0, n0, f0;
    bit got;
    pulse_reset();
    got = 0;
    a_addr = 7'h04; a_data = 8'hFF; a_v = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (a_rdy) got = 1;
    end
    a_v = 1'b0;
    r0 = rises;
    for (int k = 0; k < 200 && rises < r0 + 9; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++; if (copi !== 1'b1 || ncs !== 1'b0) begin failures++; $display("FAIL rm_pre got=%b%b exp=10", copi, ncs); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ncs, sclk, copi, busy} !== 4'b1000) begin failures++; $display("FAIL rm_async got=%b exp=1000", {ncs, sclk, copi, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    r0 = rises; n0 = low_total; f0 = fd_cnt;
    repeat (500) @(negedge clk);
    checks++; if (rises != r0) begin failures++; $display("FAIL rm_sclk_idle got=%0d exp=0", rises - r0); end
    checks++; if (low_total != n0) begin failures++; $display("FAIL rm_ncs_idle got=%0d exp=0", low_total - n0); end
    checks++; if (fd_cnt != f0) begin failures++; $display("FAIL rm_no_done got=%0d exp=0", fd_cnt - f0); end
  endtask

  task automatic test_div3();
    int r2, hi, lo, bad_hi, bad_lo, first_lo, nlow2, rb;
    logic sp;
    logic [16:0] lg, exp2;
    bit done;
    logic busy_at_done;
    r2 = 0; hi = 0; lo = 0; bad_hi = 0; bad_lo = 0; first_lo = -1;
    nlow2 = 0; rb = 0; sp = 1'b0; lg = '0; done = 0; busy_at_done = 1'b0;
    exp2 = {1'b1, 7'h01, 8'h55, 1'b0};
    addr2 = 7'h01; data2 = 8'h55; v2 = 1'b1;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      if (rdy2) v2 = 1'b0;
      if (rdyb2) rb++;
      if (!ncs2) nlow2++;
      if (sclk2) begin
        if (!sp) begin
          r2++;
          lg = {lg[15:0], copi2};
          if (first_lo < 0) first_lo = lo;
          else if (lo != 3) bad_lo++;
          lo = 0;
        end
        hi++;
      end else begin
        if (sp) begin
          if (hi != 3) bad_hi++;
          hi = 0;
        end
        if (!ncs2) lo++;
      end
      sp = sclk2;
      if (fd2) begin
        done = 1;
        busy_at_done = busy2;
      end
    end
    v2 = 1'b0;
    checks++; if (!done) begin failures++; $display("FAIL d3_done got=0 exp=1"); end
    checks++; if (r2 != 17) begin failures++; $display("FAIL d3_rises got=%0d exp=17", r2); end
    checks++; if (bad_hi != 0) begin failures++; $display("FAIL d3_high_len got=%0d exp=0", bad_hi); end
    checks++; if (bad_lo != 0) begin failures++; $display("FAIL d3_low_len got=%0d exp=0", bad_lo); end
    checks++; if (first_lo != 5) begin failures++; $display("FAIL d3_first_low got=%0d exp=5", first_lo); end
    checks++; if (nlow2 != 107) begin failures++; $display("FAIL d3_ncs_low got=%0d exp=107", nlow2); end
    checks++; if (lg !== exp2) begin failures++; $display("FAIL d3_bits got=%b exp=%b", lg, exp2); end
    checks++; if (rb != 0 || busy_at_done !== 1'b1) begin failures++; $display("FAIL d3_misc got=%0d,%b exp=0,1", rb, busy_at_done); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_skip();
    int lat, bcyc, nlow;
    int e_lat, e_b, e_low;
`ifdef SPI_CFG_SKIP_REDUNDANT_EN
    e_lat = 1; e_b = 1; e_low = 0;
`else
    e_lat = 145; e_b = 149; e_low = 144;
`endif
    pulse_reset();
    do_write(7'h00, 8'h0F, lat, bcyc, nlow);
    checks++; if (nlow != 144 || lat != 145) begin failures++; $display("FAIL sk_w1 got=%0d,%0d exp=144,145", nlow, lat); end
    do_write(7'h00, 8'h0F, lat, bcyc, nlow);
    checks++; if (nlow != e_low) begin failures++; $display("FAIL sk_w2_ncs got=%0d exp=%0d", nlow, e_low); end
    checks++; if (lat != e_lat) begin failures++; $display("FAIL sk_w2_lat got=%0d exp=%0d", lat, e_lat); end
    checks++; if (bcyc != e_b) begin failures++; $display("FAIL sk_w2_busy got=%0d exp=%0d", bcyc, e_b); end
    do_write(7'h00, 8'h00, lat, bcyc, nlow);
    checks++; if (nlow != 144 || lat != 145) begin failures++; $display("FAIL sk_w3 got=%0d,%0d exp=144,145", nlow, lat); end
    do_write(7'h05, 8'h00, lat, bcyc, nlow);
    checks++; if (nlow != 144) begin failures++; $display("FAIL sk_hi_addr got=%0d exp=144", nlow); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_v = 1'b0; a_addr = '0; a_data = '0;
    b_v = 1'b0; b_addr = '0; b_data = '0;
    v2 = 1'b0; addr2 = '0; data2 = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_wait();
    test_reset_mid();
    test_div3();
    test_skip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
